ysyx_22050133_lsu: RTL and testbench

Memory-access stage directly downstream of the execute stage. Consumes the execute result (as address or pass-through value), store data and memory control; performs byte-aligned loads and stores over a single-outstanding valid/ready memory port. Produces the writeback value and the memory-stage forwarding value fed back to execute. Multi-cycle bus latency is absorbed by back-pressuring execute via `in_ready`.

---
 rtl/ysyx_22050133_lsu_if.sv | 15 +
 rtl/ysyx_22050133_lsu.sv | 96 +++++++++
 tb/tb_ysyx_22050133_lsu.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_lsu_if.sv
// ysyx_22050133_lsu_if: single-outstanding valid/ready memory port between the LSU and memory
interface ysyx_22050133_lsu_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wmask;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  modport master (output req_valid, req_we, req_addr, req_wdata, req_wmask,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_wmask,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/ysyx_22050133_lsu.sv
// ysyx_22050133_lsu: memory-access stage with byte-aligned loads/stores over a valid/ready port.
// Define YSYX_22050133_LSU_MISALIGN_CHK_EN to flag misaligned accesses instead of issuing them.
module ysyx_22050133_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  ctrl_mem,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [4:0]  rd,
  input  logic        wen,
  ysyx_22050133_lsu_if.master bus,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_wen,
  output logic        misalign,
  output logic [63:0] forward_data_mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state;
  logic        ld_q, uns_q;
  logic [1:0]  sz_q;
  logic [2:0]  off_q;
  logic        accept, mem_op, mis;
  logic [7:0]  bytes, mask;
  logic [63:0] sh, ld_val;
  assign in_ready = (state == IDLE) | (state == DONE & out_ready);
  assign accept = in_valid & in_ready;
  assign mem_op = ctrl_mem[4] | ctrl_mem[3];
`ifdef YSYX_22050133_LSU_MISALIGN_CHK_EN
  assign mis = mem_op & (ctrl_mem[1:0] == 2'd1 ? addr[0] :
                         ctrl_mem[1:0] == 2'd2 ? |addr[1:0] :
                         ctrl_mem[1:0] == 2'd3 ? |addr[2:0] : 1'b0);
`else
  assign mis = 1'b0;
`endif
  assign bytes = ctrl_mem[1:0] == 2'd0 ? 8'h01 : ctrl_mem[1:0] == 2'd1 ? 8'h03 :
                 ctrl_mem[1:0] == 2'd2 ? 8'h0F : 8'hFF;
  // lanes shifted past byte 7 fall off the 8-bit mask
  assign mask = bytes << addr[2:0];
  assign sh = bus.rsp_rdata >> {off_q, 3'b000};
  assign ld_val = sz_q == 2'd0 ? {{56{~uns_q & sh[7]}}, sh[7:0]} :
                  sz_q == 2'd1 ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
                  sz_q == 2'd2 ? {{32{~uns_q & sh[31]}}, sh[31:0]} : sh;
  assign forward_data_mem = out_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ld_q          <= 1'b0;
      uns_q         <= 1'b0;
      sz_q          <= 2'd0;
      off_q         <= 3'd0;
      bus.req_valid <= 1'b0;
      bus.req_we    <= 1'b0;
      bus.req_addr  <= '0;
      bus.req_wdata <= 64'd0;
      bus.req_wmask <= 8'd0;
      out_valid     <= 1'b0;
      out_data      <= 64'd0;
      out_rd        <= 5'd0;
      out_wen       <= 1'b0;
      misalign      <= 1'b0;
    end else if (accept) begin
      ld_q          <= ctrl_mem[4];
      uns_q         <= ctrl_mem[2];
      sz_q          <= ctrl_mem[1:0];
      off_q         <= addr[2:0];
      bus.req_valid <= mem_op & ~mis;
      bus.req_we    <= ctrl_mem[3];
      bus.req_addr  <= {addr[ADDR_W-1:3], 3'b000};
      bus.req_wdata <= wdata << {addr[2:0], 3'b000};
      bus.req_wmask <= mask;
      out_valid     <= ~mem_op | mis;
      out_data      <= mem_op ? 64'd0 : addr;
      out_rd        <= rd;
      out_wen       <= wen & ~mis;
      misalign      <= mis;
      state         <= mem_op & ~mis ? REQ : DONE;
    end else if (state == DONE & out_ready) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end else if (state == REQ & bus.req_ready) begin
      bus.req_valid <= 1'b0;
      state         <= WAIT;
    end else if (state == WAIT & bus.rsp_valid) begin
      out_valid <= 1'b1;
      out_data  <= ld_q ? ld_val : 64'd0;
      state     <= DONE;
    end
  end
endmodule

// File: tb/tb_ysyx_22050133_lsu.sv
// tb_ysyx_22050133_lsu: scoreboard bench with a responding memory model and a writeback monitor
module tb_ysyx_22050133_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  ctrl_mem = '0, rd = '0;
  logic [63:0] addr = '0, wdata = '0;
  logic        wen = 1'b0;
  logic        out_valid, out_ready, out_wen, misalign;
  logic [63:0] out_data, forward_data_mem;
  logic [4:0]  out_rd;
  ysyx_22050133_lsu_if #(.ADDR_W(32)) bus();
  ysyx_22050133_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_mem(ctrl_mem), .addr(addr), .wdata(wdata), .rd(rd), .wen(wen),
    .bus(bus), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_wen(out_wen), .misalign(misalign), .forward_data_mem(forward_data_mem)
  );
  always #5 clk = ~clk;

  typedef struct {logic [63:0] data; logic [4:0] rd; logic wen; logic mis;} out_t;
  typedef struct {logic we; logic [31:0] a; logic [63:0] wd; logic [7:0] m; logic [63:0] rdata;} req_t;
  out_t exp_out[$];
  req_t exp_req[$];
  int checks = 0, errors = 0;
  int rr_cnt = 0, rsp_delay = 0, hold = 0, pend = 0, cyc = 0;
  logic [63:0] cur_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: stalls req_ready by rr_cnt, answers rsp_delay cycles after the handshake
  initial begin
    req_t e;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.rsp_valid = 1'b1;
          bus.rsp_rdata = cur_rdata;
        end
      end
      bus.req_ready = 1'b0;
      if (bus.req_valid) begin
        if (exp_req.size() == 0) chk("unexpected_req", 1, 0);
        else if (rr_cnt > 0) begin
          rr_cnt--;
          chk("req_addr_stalled", bus.req_addr, exp_req[0].a);
        end else begin
          bus.req_ready = 1'b1;
          e = exp_req.pop_front();
          chk("req_we", bus.req_we, e.we);
          chk("req_addr", bus.req_addr, e.a);
          chk("req_wdata", bus.req_wdata, e.wd);
          chk("req_wmask", bus.req_wmask, e.m);
          cur_rdata = e.rdata;
          pend = rsp_delay + 1;
        end
      end
    end
  end

  // writeback monitor: drives out_ready, checks hold stability and pops on handshake
  initial begin
    out_t e;
    logic held = 1'b0;
    logic [63:0] held_data = '0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid && hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else out_ready = 1'b1;
      if (out_valid) begin
        if (held) chk("out_data_hold", out_data, held_data);
        held = !out_ready;
        held_data = out_data;
        if (out_ready) begin
          if (exp_out.size() == 0) chk("unexpected_out", 1, 0);
          else begin
            e = exp_out.pop_front();
            chk("out_data", out_data, e.data);
            chk("forward_data_mem", forward_data_mem, e.data);
            chk("out_rd", out_rd, e.rd);
            chk("out_wen", out_wen, e.wen);
            chk("misalign", misalign, e.mis);
          end
        end
      end else held = 1'b0;
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask

  task automatic lat(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_out.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 200) chk("drain_timeout", 0, 1);
  endtask

  task automatic send(input logic [4:0] c, input logic [63:0] a, wd, input logic [4:0] r,
                      input logic w, push, input logic [63:0] od, input logic ow, om, dreq, we,
                      input logic [31:0] ra, input logic [63:0] rwd, input logic [7:0] m,
                      input logic [63:0] rdat);
    int n;
    out_t o;
    req_t q;
    wait_ready(n);
    if (push) begin
      o.data = od; o.rd = r; o.wen = ow; o.mis = om;
      exp_out.push_back(o);
    end
    if (dreq) begin
      q.we = we; q.a = ra; q.wd = rwd; q.m = m; q.rdata = rdat;
      exp_req.push_back(q);
    end
    ctrl_mem = c; addr = a; wdata = wd; rd = r; wen = w; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0, v;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_valid", bus.req_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_out_wen", out_wen, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    send(5'b00000, 64'h1234, 0, 5'd5, 1, 1, 64'h1234, 1, 0, 0, 0, 0, 0, 0, 0);
    lat(n); chk("nonmem_latency", n, 0);
    drain();
    send(5'b10000, 64'h80000003, 0, 5'd1, 1, 1, 64'hFFFFFFFF_FFFFFF80, 1, 0,
         1, 0, 32'h80000000, 0, 8'h08, 64'h00000000_80FF0000);
    lat(n); chk("load_latency", n, 2);
    drain();
    send(5'b10100, 64'h80000003, 0, 5'd2, 1, 1, 64'h80, 1, 0,
         1, 0, 32'h80000000, 0, 8'h08, 64'h00000000_80FF0000);
    send(5'b01001, 64'h80000006, 64'hBEEF, 5'd7, 0, 1, 0, 0, 0,
         1, 1, 32'h80000000, 64'hBEEF0000_00000000, 8'hC0, 0);
    send(5'b10010, 64'h100, 0, 5'd8, 1, 1, 64'hFFFFFFFF_8899AABB, 1, 0,
         1, 0, 32'h100, 0, 8'h0F, 64'h11223344_8899AABB);
    send(5'b10110, 64'h104, 0, 5'd9, 1, 1, 64'h11223344, 1, 0,
         1, 0, 32'h100, 0, 8'hF0, 64'h11223344_8899AABB);
    send(5'b10001, 64'h102, 0, 5'd10, 1, 1, 64'hFFFFFFFF_FFFF8899, 1, 0,
         1, 0, 32'h100, 0, 8'h0C, 64'h11223344_8899AABB);
    send(5'b10111, 64'h108, 0, 5'd11, 1, 1, 64'h11223344_8899AABB, 1, 0,
         1, 0, 32'h108, 0, 8'hFF, 64'h11223344_8899AABB);
    send(5'b01011, 64'h200, 64'h01234567_89ABCDEF, 5'd0, 0, 1, 0, 0, 0,
         1, 1, 32'h200, 64'h01234567_89ABCDEF, 8'hFF, 0);
    send(5'b01000, 64'h205, 64'hFFFFFFFF_FFFFFFAB, 5'd0, 0, 1, 0, 0, 0,
         1, 1, 32'h200, 64'hFFFFAB00_00000000, 8'h20, 0);
    drain();
    c0 = cyc;
    send(5'b00000, 64'h11, 0, 5'd1, 1, 1, 64'h11, 1, 0, 0, 0, 0, 0, 0, 0);
    send(5'b00000, 64'h22, 0, 5'd2, 1, 1, 64'h22, 1, 0, 0, 0, 0, 0, 0, 0);
    send(5'b00000, 64'h33, 0, 5'd3, 0, 1, 64'h33, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("back_to_back_cycles", cyc - c0, 3);
    drain();
    // 3 stalled REQ + handshake + 3 WAIT + 2 stalled DONE cycles with in_ready low
    rr_cnt = 3; rsp_delay = 2; hold = 2;
    send(5'b10010, 64'h300, 0, 5'd12, 1, 1, 64'h7FFFFFFF, 1, 0,
         1, 0, 32'h300, 0, 8'h0F, 64'h7FFFFFFF);
    wait_ready(n); chk("stall_in_ready_low", n, 9);
    rsp_delay = 0;
    drain();
`ifdef YSYX_22050133_LSU_MISALIGN_CHK_EN
    send(5'b10010, 64'h2, 0, 5'd3, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    lat(n); chk("misalign_latency", n, 0);
    send(5'b10001, 64'h1, 0, 5'd4, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    send(5'b01011, 64'h4, 64'h55, 5'd0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
`else
    send(5'b10010, 64'h2, 0, 5'd3, 1, 1, 64'hFFFFFFFF_CCDDEEFF, 1, 0,
         1, 0, 32'h0, 0, 8'h3C, 64'hAABBCCDD_EEFF0011);
    send(5'b01010, 64'h6, 64'h11223344, 5'd0, 0, 1, 0, 0, 0,
         1, 1, 32'h0, 64'h33440000_00000000, 8'hC0, 0);
`endif
    drain();
    rsp_delay = 4;
    send(5'b10011, 64'h400, 0, 5'd13, 1, 0, 0, 0, 0,
         1, 0, 32'h400, 0, 8'hFF, 64'hDEADBEEF);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("wait_rst_req_valid", bus.req_valid, 0);
    chk("wait_rst_out_valid", out_valid, 0);
    chk("wait_rst_in_ready", in_ready, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    v = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (out_valid) v++;
    end
    chk("late_rsp_ignored", v, 0);
    rsp_delay = 0;
    hold = 5;
    send(5'b00000, 64'hDEAD, 0, 5'd14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("done_before_rst", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("done_rst_out_valid", out_valid, 0);
    chk("done_rst_in_ready", in_ready, 1);
    hold = 0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    send(5'b00000, 64'hCAFE, 0, 5'd15, 1, 1, 64'hCAFE, 1, 0, 0, 0, 0, 0, 0, 0);
    drain();
    chk("out_queue_empty", exp_out.size(), 0);
    chk("req_queue_empty", exp_req.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
